// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared constants for the RV32I datapath blocks.
//   XLEN       : architectural register width
//   ARB_FIXED  : arbiter mode, lowest requesting index wins
//   ARB_RR     : arbiter mode, round-robin starting at a rotating pointer
//   clog2()    : ceiling log2 for flows that lack $clog2
//   arb_mode_e : typed view of the two arbitration modes
// ---------------------------------------------------------------------------
package rv32i_pkg;

   localparam int XLEN      = 32;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef enum logic [0:0] {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } arb_mode_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mux_arb_rv32i_if.sv
// ---------------------------------------------------------------------------
// mux_arb_rv32i_if
// Bundle of the N-input valid/ready mux signals.
//   in_data/in_valid/in_ready : N_IN producer channels, channel i at [i*WIDTH +: WIDTH]
//   force_en/force_sel        : bypass arbitration and only allow force_sel
//   out_data/out_valid/out_ready/out_sel : registered consumer side
// Modports:
//   master : the environment (producers + consumer)
//   slave  : the mux itself
// ---------------------------------------------------------------------------
interface mux_arb_rv32i_if #(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4,
   parameter int SEL_W = $clog2(N_IN)
);

   logic [N_IN*WIDTH-1:0] in_data;
   logic [N_IN-1:0]       in_valid;
   logic [N_IN-1:0]       in_ready;
   logic                  force_en;
   logic [SEL_W-1:0]      force_sel;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_W-1:0]      out_sel;

   modport master (
      output in_data, in_valid, force_en, force_sel, out_ready,
      input  in_ready, out_data, out_valid, out_sel
   );

   modport slave (
      input  in_data, in_valid, force_en, force_sel, out_ready,
      output in_ready, out_data, out_valid, out_sel
   );

endinterface

// File: rtl/rr_arbiter_rv32i.sv
// ---------------------------------------------------------------------------
// rr_arbiter_rv32i
// Purely combinational N_IN-requester arbiter.
//   req       : request vector
//   ptr       : round-robin start index (ignored in fixed-priority mode)
//   force_en  : only force_sel may be granted
//   force_sel : forced index; values >= N_IN never grant
//   grant     : one-hot grant (zero when nobody wins)
//   grant_idx : encoded index of the winner (0 when nobody wins)
//   grant_vld : a grant exists
// ---------------------------------------------------------------------------
module rr_arbiter_rv32i
   import rv32i_pkg::*;
#(
   parameter int N_IN    = 4,
   parameter int SEL_W   = $clog2(N_IN),
   parameter int RR_MODE = ARB_RR
) (
   input  logic [N_IN-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             force_en,
   input  logic [SEL_W-1:0] force_sel,
   output logic [N_IN-1:0]  grant,
   output logic [SEL_W-1:0] grant_idx,
   output logic             grant_vld
);

   int               idx_i;
   logic [SEL_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      idx_i     = 0;
      idx       = '0;
      if (force_en) begin
         if (int'(force_sel) < N_IN) begin
            if (req[force_sel]) begin
               grant_vld        = 1'b1;
               grant_idx        = force_sel;
               grant[force_sel] = 1'b1;
            end
         end
      end else begin
         // Scan from ptr (or from 0) and wrap by subtraction so that
         // non-power-of-two N_IN wraps at N_IN rather than at 2**SEL_W.
         for (int k = 0; k < N_IN; k++) begin
            idx_i = (RR_MODE == ARB_RR) ? int'(ptr) + k : k;
            if (idx_i >= N_IN) begin
               idx_i = idx_i - N_IN;
            end
            idx = idx_i[SEL_W-1:0];
            if (!grant_vld && req[idx]) begin
               grant_vld  = 1'b1;
               grant_idx  = idx;
               grant[idx] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mux_arb_rv32i.sv
// ---------------------------------------------------------------------------
// mux_arb_rv32i
// N-input arbitrated mux with per-channel valid/ready and a registered output.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : mux_arb_rv32i_if.slave (inputs, force controls, output stage)
// The output register accepts a new word whenever it is empty or being
// consumed this cycle (load), giving 1-cycle latency and full throughput.
// ---------------------------------------------------------------------------
module mux_arb_rv32i
   import rv32i_pkg::*;
#(
   parameter int WIDTH   = XLEN,
   parameter int N_IN    = 4,
   parameter int SEL_W   = $clog2(N_IN),
   parameter int RR_MODE = ARB_RR
) (
   input  logic            clk,
   input  logic            rst_n,
   mux_arb_rv32i_if.slave  bus
);

   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_sel_q,   out_sel_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

   logic             load;
   logic [N_IN-1:0]  grant;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_vld;

   rr_arbiter_rv32i #(
      .N_IN    (N_IN),
      .SEL_W   (SEL_W),
      .RR_MODE (RR_MODE)
   ) u_arb (
      .req       (bus.in_valid),
      .ptr       (rr_ptr_q),
      .force_en  (bus.force_en),
      .force_sel (bus.force_sel),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   assign load = ~out_valid_q | bus.out_ready;

   // Grant is only exposed when the output register can take the word;
   // held low during reset so no producer believes it was accepted.
   assign bus.in_ready = (rst_n && load) ? grant : '0;

   always_comb begin
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         if (grant_vld) begin
            out_data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (RR_MODE == ARB_RR) begin
               rr_ptr_d = (int'(grant_idx) == N_IN - 1) ? '0 : grant_idx + 1'b1;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_rv32i.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_rv32i
// Directed bench for mux_arb_rv32i: a round-robin N_IN=4 instance, a
// fixed-priority N_IN=4 instance and a round-robin N_IN=3 instance.
// ---------------------------------------------------------------------------
module tb_mux_arb_rv32i;

   logic clk;
   logic rst_n;

   int n_chk;
   int n_fail;

   mux_arb_rv32i_if #(.WIDTH(32), .N_IN(4)) if_rr ();
   mux_arb_rv32i_if #(.WIDTH(32), .N_IN(4)) if_fp ();
   mux_arb_rv32i_if #(.WIDTH(32), .N_IN(3)) if_n3 ();

   mux_arb_rv32i #(.WIDTH(32), .N_IN(4), .RR_MODE(1)) u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_rr)
   );

   mux_arb_rv32i #(.WIDTH(32), .N_IN(4), .RR_MODE(0)) u_fp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_fp)
   );

   mux_arb_rv32i #(.WIDTH(32), .N_IN(3), .RR_MODE(1)) u_n3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_n3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s got=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;

      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if_rr.in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
         if_fp.in_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);
      end
      for (int i = 0; i < 3; i++) begin
         if_n3.in_data[i*32 +: 32] = 32'hC000_0000 + 32'(i);
      end
      if_rr.in_valid = 4'b1111;  if_rr.out_ready = 1'b1;
      if_rr.force_en = 1'b0;     if_rr.force_sel = 2'd0;
      if_fp.in_valid = 4'b0000;  if_fp.out_ready = 1'b1;
      if_fp.force_en = 1'b0;     if_fp.force_sel = 2'd0;
      if_n3.in_valid = 3'b000;   if_n3.out_ready = 1'b1;
      if_n3.force_en = 1'b0;     if_n3.force_sel = 2'd0;

      // Reset held for two edges with all channels requesting
      step();
      step();
      chk("rst_out_valid", 32'(if_rr.out_valid), 32'd0);
      chk("rst_out_data",  if_rr.out_data,       32'd0);
      chk("rst_out_sel",   32'(if_rr.out_sel),   32'd0);
      chk("rst_in_ready",  32'(if_rr.in_ready),  32'b0000);

      rst_n = 1'b1;
      #1;
      chk("rr_first_ready", 32'(if_rr.in_ready), 32'b0001);

      // Round-robin fairness: 0,1,2,3,0 on consecutive cycles
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_seq_sel",   32'(if_rr.out_sel),   32'(i % 4));
         chk("rr_seq_data",  if_rr.out_data,       32'hA000_0000 + 32'(i % 4));
         chk("rr_seq_valid", 32'(if_rr.out_valid), 32'd1);
         chk("rr_seq_ready", 32'(if_rr.in_ready),  32'(1 << ((i + 1) % 4)));
      end

      // Backpressure on word from channel 1
      step();
      chk("bp_sel1", 32'(if_rr.out_sel), 32'd1);
      chk("bp_data1", if_rr.out_data, 32'hA000_0001);
      if_rr.out_ready = 1'b0;
      #1;
      chk("bp_ready_low", 32'(if_rr.in_ready), 32'b0000);
      if_rr.in_data[2*32 +: 32] = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_data",  if_rr.out_data,       32'hA000_0001);
         chk("bp_hold_sel",   32'(if_rr.out_sel),   32'd1);
         chk("bp_hold_valid", 32'(if_rr.out_valid), 32'd1);
         chk("bp_hold_ready", 32'(if_rr.in_ready),  32'b0000);
      end
      if_rr.in_data[2*32 +: 32] = 32'hA000_0002;
      if_rr.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(if_rr.in_ready), 32'b0100);
      step();
      chk("bp_next_sel",  32'(if_rr.out_sel), 32'd2);
      chk("bp_next_data", if_rr.out_data,     32'hA000_0002);

      // Force channel 3
      if_rr.force_en  = 1'b1;
      if_rr.force_sel = 2'd3;
      if_rr.in_data[3*32 +: 32] = 32'hDEAD_BEEF;
      #1;
      chk("force_ready", 32'(if_rr.in_ready), 32'b1000);
      step();
      chk("force_data", if_rr.out_data,     32'hDEAD_BEEF);
      chk("force_sel",  32'(if_rr.out_sel), 32'd3);
      if_rr.in_valid = 4'b0111;
      #1;
      chk("force_nogrant_ready", 32'(if_rr.in_ready), 32'b0000);
      step();
      chk("force_drop_valid", 32'(if_rr.out_valid), 32'd0);
      chk("force_hold_data",  if_rr.out_data,       32'hDEAD_BEEF);
      chk("force_hold_sel",   32'(if_rr.out_sel),   32'd3);

      // Forced grant of 3 wrapped the pointer to 0
      if_rr.force_en = 1'b0;
      if_rr.in_valid = 4'b1111;
      if_rr.in_data[3*32 +: 32] = 32'hA000_0003;
      step();
      chk("wrap_sel0", 32'(if_rr.out_sel), 32'd0);
      step();
      chk("wrap_sel1", 32'(if_rr.out_sel), 32'd1);

      // Reset mid-stream with out_valid=1 and pointer at 2
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(if_rr.in_ready), 32'b0000);
      step();
      chk("midrst_valid", 32'(if_rr.out_valid), 32'd0);
      chk("midrst_data",  if_rr.out_data,       32'd0);
      rst_n = 1'b1;
      step();
      chk("midrst_first_sel",   32'(if_rr.out_sel),   32'd0);
      chk("midrst_first_valid", 32'(if_rr.out_valid), 32'd1);

      // Fixed priority: channel 1 wins over 2 until it drops
      if_fp.in_valid = 4'b0110;
      #1;
      chk("fp_ready1", 32'(if_fp.in_ready), 32'b0010);
      step();
      chk("fp_sel_a", 32'(if_fp.out_sel), 32'd1);
      chk("fp_data_a", if_fp.out_data, 32'hB000_0001);
      step();
      chk("fp_sel_b", 32'(if_fp.out_sel), 32'd1);
      if_fp.in_valid = 4'b0100;
      #1;
      chk("fp_ready2", 32'(if_fp.in_ready), 32'b0100);
      step();
      chk("fp_sel_c",  32'(if_fp.out_sel), 32'd2);
      chk("fp_data_c", if_fp.out_data,     32'hB000_0002);
      if_fp.in_valid = 4'b0000;
      step();
      chk("fp_idle_valid", 32'(if_fp.out_valid), 32'd0);

      // N_IN=3 wrap 2 -> 0, and out-of-range forced select
      if_n3.in_valid = 3'b111;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("n3_seq_sel",  32'(if_n3.out_sel), 32'(i % 3));
         chk("n3_seq_data", if_n3.out_data,     32'hC000_0000 + 32'(i % 3));
      end
      if_n3.force_en  = 1'b1;
      if_n3.force_sel = 2'd3;
      #1;
      chk("n3_force_oor_ready", 32'(if_n3.in_ready), 32'b000);
      step();
      chk("n3_force_oor_valid", 32'(if_n3.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_arb_rv32i.md
Name: mux_arb_rv32i

Overview:
Parametrised N-input, WIDTH-bit multiplexer with per-input valid/ready handshakes and a registered output stage. It is the successor of the 2-to-1 datapath mux. Selection is arbitrated (fixed-priority or round-robin), or forced by an explicit select, which preserves plain-mux usage. It sits between multiple RV32I datapath producers (e.g. ALU, load unit, CSR path) and a single shared consumer such as register-file writeback or a shared memory port.

Parameters:
WIDTH, 32, data width of each input and the output
N_IN, 4, number of input channels (2..16)
SEL_W, $clog2(N_IN), width of select/index fields
RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_data  input  N_IN*WIDTH  packed input data, channel i at [i*WIDTH +: WIDTH]
in_valid  input  N_IN  channel i offers data
in_ready  output  N_IN  channel i data accepted this cycle
force_en  input  1  1 = bypass arbitration, only force_sel may be granted
force_sel  input  SEL_W  forced channel index
out_data  output  WIDTH  registered selected data
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data
out_sel  output  SEL_W  index of the channel that produced out_data

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is combinational and is 0 while rst_n=0.
- load = ~out_valid | out_ready. A new word can enter the output register only when load=1.
- Arbitration (combinational, evaluated every cycle):
  - force_en=1: candidate = force_sel if in_valid[force_sel]=1, else none. force_sel >= N_IN means no grant.
  - RR_MODE=1: first valid index scanning rr_ptr, rr_ptr+1, …, wrapping modulo N_IN.
  - RR_MODE=0: lowest valid index.
- Handshake:
  - in_ready[g]=1 only when load=1 and g is the granted channel. At most one in_ready bit is high (one-hot or zero).
  - in_ready never depends on a channel's own in_valid except through the grant.
- Transfer on posedge when load=1 and a grant exists: out_data<=in_data[g], out_sel<=g, out_valid<=1.
  - RR_MODE=1: rr_ptr<=(g+1) mod N_IN, also updated on forced grants.
- When load=1 with no grant: out_valid<=0, while out_data and out_sel hold their values.
- When out_valid=1 and out_ready=0: output stalls. out_data, out_sel, out_valid and rr_ptr hold, and all in_ready=0.
- Latency: 1 cycle from accepted input to out_valid. Throughput is 1 word/cycle with out_ready held high.
- Simultaneous consume and load: out_ready=1 together with a grant replaces the word in the same edge, with no bubble.
- Wrap-around: rr_ptr=N_IN-1 with grant N_IN-1 wraps to 0. Non-power-of-two N_IN must wrap correctly (e.g. N_IN=3: 2 -> 0).
- Starvation: in RR_MODE=1, a continuously valid channel is granted within N_IN accepted transfers.
- Reset mid-operation: a pending out_valid word is dropped and rr_ptr returns to 0 on the next edge.
- Input data may change freely while in_ready=0. Only data present on a cycle with in_ready=1 is captured.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN=32 constant
  - ARB_FIXED=0 and ARB_RR=1 mode constants
  - a clog2 helper function, if the tool flow lacks $clog2
- Sub-module rr_arbiter_rv32i: pure combinational N_IN requester arbiter.
  - Inputs: req, ptr, force_en, force_sel.
  - Outputs: one-hot grant plus encoded index.
  - It is reused later by memory-port sharing.
- Top level holds the output register, rr_ptr and the handshake logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Round-robin fairness: N_IN=4, in_valid=1111 constant, out_ready=1, in_data[i]=32'hA000_000i -> out_sel sequence 0,1,2,3,0 on consecutive cycles, exactly one in_ready bit high per cycle.
- Backpressure: out_valid=1 with out_data=32'hA000_0001, then out_ready=0 for 3 cycles -> out_data/out_sel held, in_ready=0000. Release out_ready -> next grant is channel 2 with no lost word.
- Fixed priority: RR_MODE=0, in_valid=0110 -> channel 1 granted repeatedly, channel 2 only after in_valid[1] drops.
- Force mode: force_en=1, force_sel=3, in_valid=1111, in_data[3]=32'hDEAD_BEEF -> out_data=32'hDEAD_BEEF, out_sel=3, in_ready=1000. Then in_valid[3]=0 -> no grant, out_valid drops after consumption.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and rr_ptr=2 -> next edge out_valid=0. After release with in_valid=1111, the first out_sel is 0.
